// File: rtl/mext_pkg.sv
// Shared definitions for the RV32M multiply execute stage: op encodings,
// the stage-1 payload layout and the operand magnitude helper.
package mext_pkg;

  localparam int XLEN      = 32;
  localparam int TAG_WIDTH = 5;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;
  localparam logic [1:0] OP_MULHU  = 2'b11;

  typedef struct packed {
    logic [XLEN-1:0]      mag_a;
    logic [XLEN-1:0]      mag_b;
    logic                 neg;
    logic [1:0]           op;
    logic [TAG_WIDTH-1:0] tag;
  } s1_payload_t;

  // Two's-complement magnitude; 0x80000000 maps to itself, which is the
  // correct magnitude when read as unsigned.
  function automatic logic [XLEN-1:0] magnitude(input logic [XLEN-1:0] v,
                                                input logic            is_signed);
    return (is_signed && v[XLEN-1]) ? (~v + XLEN'(1)) : v;
  endfunction

endpackage

// File: rtl/umul32_core.sv
// Purely combinational unsigned 32x32 -> 64-bit product.
module umul32_core (
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic [63:0] p_o
);

  assign p_o = {32'b0, a_i} * {32'b0, b_i};

endmodule

// File: rtl/mul_exec_unit.sv
// Two-stage RV32M multiply execute unit: S1 registers operand magnitudes and
// the result sign, S2 registers the sign-corrected, word-selected product.
module mul_exec_unit #(
  parameter int TAG_W = mext_pkg::TAG_WIDTH,
  parameter int XLEN  = mext_pkg::XLEN
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [XLEN-1:0]  in_rs1,
  input  logic [XLEN-1:0]  in_rs2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_result,
  output logic [TAG_W-1:0] out_tag
);

  import mext_pkg::s1_payload_t;
  import mext_pkg::OP_MUL;
  import mext_pkg::OP_MULH;
  import mext_pkg::OP_MULHSU;
  import mext_pkg::magnitude;

  // Handshake: a transfer happens on an edge where valid && ready; a producer
  // holding valid keeps its payload stable until that edge. in_ready depends
  // only on stage occupancy and out_ready, never on in_valid.
  s1_payload_t      s1_q, s1_d;
  logic             s1_valid_q, s1_valid_d;
  logic             s2_valid_q, s2_valid_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             s2_free;
  logic             s1_adv;
  logic             accept;
  logic             a_signed;
  logic             b_signed;
  logic             a_neg;
  logic             b_neg;
  logic [2*XLEN-1:0] prod;
  logic [2*XLEN-1:0] signed_prod;

  umul32_core u_core (
    .a_i (s1_q.mag_a),
    .b_i (s1_q.mag_b),
    .p_o (prod)
  );

  always_comb begin
    s2_free  = !s2_valid_q || out_ready;
    s1_adv   = s1_valid_q && s2_free;
    in_ready = !s1_valid_q || s2_free;
    accept   = in_valid && in_ready;

    a_signed = (in_op == OP_MULH) || (in_op == OP_MULHSU);
    b_signed = (in_op == OP_MULH);
    a_neg    = a_signed && in_rs1[XLEN-1];
    b_neg    = b_signed && in_rs2[XLEN-1];

    signed_prod = s1_q.neg ? (~prod + 64'd1) : prod;

    s1_d       = s1_q;
    s1_valid_d = s1_valid_q;
    s2_valid_d = s2_valid_q;
    result_d   = result_q;
    tag_d      = tag_q;

    if (accept) begin
      s1_d.mag_a = magnitude(in_rs1, a_signed);
      s1_d.mag_b = magnitude(in_rs2, b_signed);
      s1_d.neg   = a_neg ^ b_neg;
      s1_d.op    = in_op;
      s1_d.tag   = in_tag;
    end

    if (s1_adv) begin
      result_d = (s1_q.op == OP_MUL) ? signed_prod[XLEN-1:0]
                                     : signed_prod[2*XLEN-1:XLEN];
      tag_d    = s1_q.tag;
    end

    // Flush wins over every advance; stale data left in the registers is
    // never exposed because both valid bits drop.
    if (flush) begin
      s1_valid_d = 1'b0;
      s2_valid_d = 1'b0;
    end else begin
      if (s1_adv)         s2_valid_d = 1'b1;
      else if (out_ready) s2_valid_d = 1'b0;
      if (accept)         s1_valid_d = 1'b1;
      else if (s1_adv)    s1_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q       <= '0;
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      result_q   <= '0;
      tag_q      <= '0;
    end else begin
      s1_q       <= s1_d;
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      result_q   <= result_d;
      tag_q      <= tag_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_result = result_q;
  assign out_tag    = tag_q;

endmodule

// File: tb/tb_mul_exec_unit.sv
// Bench for mul_exec_unit: directed scenarios plus random traffic, checked every
// cycle against an arithmetic reference model and an in-flight op queue.
module tb_mul_exec_unit;

  localparam int W = 69;  // {accept cycle[31:0], tag[4:0], result[31:0]}

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_rs1 = '0;
  logic [31:0] in_rs2 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [31:0] out_result;
  logic [4:0]  out_tag;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  logic [W-1:0] exp_q[$];

  mul_exec_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_op      (in_op),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_tag     (in_tag),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_tag    (out_tag)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got running, want finished");
    bad = bad + 1;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [65:0] sa, sb, pr;
    sa = (op == 2'b01 || op == 2'b10) ? {{34{a[31]}}, a} : {34'b0, a};
    sb = (op == 2'b01) ? {{34{b[31]}}, b} : {34'b0, b};
    pr = sa * sb;
    return (op == 2'b00) ? pr[31:0] : pr[63:32];
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total = total + 1;
    if (act !== exp) begin
      bad = bad + 1;
      $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- scoreboard / compare ----------------
  // An op whose handshake is seen in cycle c is visible on the output from
  // cycle c+2 while it is the oldest op in flight.
  logic [W-1:0] front;
  logic         exp_v;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      exp_v = 1'b0;
      front = '0;
      if (exp_q.size() > 0) begin
        front = exp_q[0];
        exp_v = (cyc - int'(front[68:37])) >= 2;
      end
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_v});
      check("in_ready", {31'b0, in_ready}, {31'b0, (exp_q.size() < 2) || out_ready});
      if (exp_v && out_valid) begin
        check("out_result", out_result, front[31:0]);
        check("out_tag", {27'b0, out_tag}, {27'b0, front[36:32]});
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (exp_v && out_ready) void'(exp_q.pop_front());
        if (in_valid && in_ready)
          exp_q.push_back({cyc[31:0], in_tag, ref_mul(in_op, in_rs1, in_rs2)});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_in(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag);
    in_valid = 1'b1;
    in_op    = op;
    in_rs1   = a;
    in_rs2   = b;
    in_tag   = tag;
  endtask

  task automatic wait_accept();
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("accept_timeout", 32'd0, 32'd1);
    in_valid = 1'b0;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [4:0] tag);
    set_in(op, a, b, tag);
    wait_accept();
  endtask

  task automatic drain();
    for (int n = 0; n < 50 && exp_q.size() != 0; n++) @(posedge clk);
    #1;
    check("drain", exp_q.size(), 32'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  // ---------------- stimulus ----------------
  logic take;

  initial begin
    // model pinned by hand-computed products
    check("ref_mul_7xm3", ref_mul(2'b00, 32'd7, 32'hFFFF_FFFD), 32'hFFFF_FFEB);
    check("ref_mulh_min", ref_mul(2'b01, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("ref_mulhu_min", ref_mul(2'b11, 32'h8000_0000, 32'h8000_0000), 32'h4000_0000);
    check("ref_mulhsu_min", ref_mul(2'b10, 32'h8000_0000, 32'h8000_0000), 32'hC000_0000);
    check("ref_mulhu_ones", ref_mul(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFE);
    check("ref_mulh_ones", ref_mul(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'h0000_0000);
    check("ref_mulhsu_ones", ref_mul(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF), 32'hFFFF_FFFF);

    #3;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_result", out_result, 32'd0);
    check("rst_out_tag", {27'b0, out_tag}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // single op, then the corner products
    send(2'b00, 32'd7, 32'hFFFF_FFFD, 5'd5);
    drain();
    send(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd6);
    send(2'b11, 32'h8000_0000, 32'h8000_0000, 5'd7);
    send(2'b10, 32'h8000_0000, 32'h8000_0000, 5'd8);
    send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10);
    send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11);
    drain();

    // streaming, tags 1..4
    for (int i = 1; i <= 4; i++) send(2'(i - 1), $urandom, $urandom, 5'(i));
    drain();

    // backpressure: third op waits for out_ready
    out_ready = 1'b0;
    send(2'b00, 32'd3, 32'd4, 5'd1);
    send(2'b01, 32'hFFFF_FFF0, 32'd9, 5'd2);
    set_in(2'b10, 32'h8000_0001, 32'd2, 5'd3);
    repeat (6) @(posedge clk);
    #1 out_ready = 1'b1;
    wait_accept();
    drain();

    // flush with both stages full and an op offered
    out_ready = 1'b0;
    send(2'b00, 32'd11, 32'd12, 5'd20);
    send(2'b11, 32'd13, 32'd14, 5'd21);
    set_in(2'b00, 32'd15, 32'd16, 5'd22);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;

    // flush while an input transfer would happen
    send(2'b01, 32'd5, 32'd6, 5'd23);
    set_in(2'b00, 32'd7, 32'd8, 5'd24);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    send(2'b00, 32'd100, 32'd200, 5'd25);
    drain();

    // asynchronous reset with both stages valid
    out_ready = 1'b0;
    send(2'b00, 32'hDEAD_BEEF, 32'd3, 5'd26);
    send(2'b11, 32'hCAFE_F00D, 32'd7, 5'd27);
    #3 rst_n = 1'b0;
    #1;
    check("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("async_rst_out_result", out_result, 32'd0);
    check("async_rst_out_tag", {27'b0, out_tag}, 32'd0);
    check("async_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    send(2'b10, 32'hFFFF_FFFE, 32'd3, 5'd28);
    drain();

    // random traffic with backpressure and occasional flushes
    for (int c = 0; c < 600; c++) begin
      @(negedge clk);
      take = in_valid && in_ready;
      @(posedge clk);
      #1;
      out_ready = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 29) == 0);
      if (!in_valid || take) begin
        in_valid = ($urandom_range(0, 3) != 0);
        in_op    = 2'($urandom_range(0, 3));
        in_rs1   = pick();
        in_rs2   = pick();
        in_tag   = 5'($urandom_range(0, 31));
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
